param_alu_seq: RTL

- Parametrised, registered successor to the 4-bit add/sub/boolean ALU. Operand width is set by WIDTH.
- Supports eight operations, including shifts and a multi-cycle unsigned multiply.
- Produces carry/overflow/zero/negative flags and an internal accumulator for chained operations.
- Uses valid/ready handshakes on input and output. Sits between the operand register file and the result writeback stage.

---
 rtl/param_alu_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/param_alu_seq.sv
// ============================================================================
// param_alu_seq : registered WIDTH-bit ALU with accumulator, shift-add MUL
// Rev 1.0
// ============================================================================
`default_nettype none

module param_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_one,
  input  logic [WIDTH-1:0] operand_two,
  input  logic [2:0]       selector,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam int             MSB      = WIDTH - 1;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   w_a;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr, w_step;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c, w_alu_v;

  assign w_a    = acc_sel ? acc_q : operand_one;
  assign w_sh   = operand_two[SHW-1:0];
  assign w_sum  = {1'b0, w_a} + {1'b0, operand_two};
  assign w_diff = {1'b0, w_a} + {1'b0, ~operand_two} + (WIDTH+1)'(1);
  // The extra bit on each shift catches the last bit shifted out (0 for a zero shift).
  assign w_shl  = {1'b0, w_a} << w_sh;
  assign w_shr  = {w_a, 1'b0} >> w_sh;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign w_step      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign w_prod_next = {w_step, prod_q[WIDTH-1:1]};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (selector)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (w_a[MSB] == operand_two[MSB]) & (w_sum[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (w_a[MSB] != operand_two[MSB]) & (w_diff[MSB] != w_a[MSB]);
      end
      OP_AND:  w_alu_res = w_a & operand_two;
      OP_OR:   w_alu_res = w_a | operand_two;
      OP_XOR:  w_alu_res = w_a ^ operand_two;
      OP_SHL: begin
        w_alu_res = w_shl[WIDTH-1:0];
        w_alu_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_alu_res = w_shr[WIDTH:1];
        w_alu_c   = w_shr[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (selector == OP_MUL) begin
            state_d = S_EXEC;
            mcand_d = w_a;
            prod_d  = {{WIDTH{1'b0}}, operand_two};
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            res_d   = w_alu_res;
            hi_d    = '0;
            carry_d = w_alu_c;
            ovf_d   = w_alu_v;
            zero_d  = (w_alu_res == '0);
            neg_d   = w_alu_res[MSB];
            acc_d   = w_alu_res;
          end
        end
      end
      S_EXEC: begin
        prod_d = w_prod_next;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = w_prod_next[WIDTH-1:0];
          hi_d    = w_prod_next[2*WIDTH-1:WIDTH];
          carry_d = |w_prod_next[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          zero_d  = (w_prod_next[WIDTH-1:0] == '0);
          neg_d   = w_prod_next[MSB];
          acc_d   = w_prod_next[WIDTH-1:0];
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result_out   = res_q;
  assign result_hi    = hi_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign zero_out     = zero_q;
  assign neg_out      = neg_q;

endmodule

`default_nettype wire
